// File: rtl/bf_pkg.sv
// Shared definitions for the bf execution core: opcodes, FSM states and
// default widths.
package bf_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int STACK_D_DEF = 16;

  localparam logic [3:0] OP_RIGHT = 4'd0;
  localparam logic [3:0] OP_LEFT  = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_PUT   = 4'd4;
  localparam logic [3:0] OP_GET   = 4'd5;
  localparam logic [3:0] OP_OPEN  = 4'd6;
  localparam logic [3:0] OP_CLOSE = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_WB      = 3'd1,
    ST_SKIP    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// Bracket return stack: holds the pc of each open '[' so that ']' can jump
// back without rescanning. Only the fill level is reset; entries above it
// are dead data.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int STACK_D = STACK_D_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int CW = $clog2(STACK_D + 1);
  localparam int IW = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [CW-1:0]   cnt;
  logic [PC_W-1:0] mem [STACK_D];
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;

  assign wr_idx = IW'(cnt);
  assign rd_idx = IW'(cnt - CW'(1));
  assign full   = (cnt == CW'(STACK_D));
  assign empty  = (cnt == '0);
  assign top    = mem[rd_idx];

  // Fill level; a push on a full stack or a pop on an empty one is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Entry storage, written at the current fill level on push.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/bf_core.sv
// bf execution core: one op per cycle from a 4-bit program ROM, with
// hardware loops, forward skip over zero-cell loops, valid/ready console
// output, keyboard input, HALT and sticky error detection.
module bf_core
  import bf_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int STACK_D = STACK_D_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        i_prg,
  input  logic [DATA_W-1:0] i_din,
  output logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] cursor,
  output logic [DATA_W-1:0] out,
  output logic              we,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halted,
  output logic              error
);

  state_t          state;
  logic [PC_W-1:0] depth;
  logic [PC_W-1:0] pc_inc;
  logic            din_zero;
  logic            stk_push;
  logic            stk_pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;

  assign pc_inc   = pc + PC_W'(1);
  assign din_zero = (i_din == '0);

  bf_loop_stack #(
    .STACK_D (STACK_D),
    .PC_W    (PC_W)
  ) u_stack (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (pc),
    .top     (stk_top),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // Stack strobes: push on a taken '[', pop when ']' falls through.
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (state == ST_RUN) begin
      if (i_prg == OP_OPEN && !din_zero && !stk_full) stk_push = 1'b1;
      if (i_prg == OP_CLOSE && din_zero && !stk_empty) stk_pop = 1'b1;
    end
  end

  // Main FSM with all datapath and handshake registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      depth    <= '0;
      pc       <= '0;
      cursor   <= '0;
      out      <= '0;
      we       <= 1'b0;
      kbd_ack  <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      halted   <= 1'b0;
      error    <= 1'b0;
    end else begin
      we      <= 1'b0;
      kbd_ack <= 1'b0;
      case (state)
        ST_RUN: begin
          case (i_prg)
            OP_RIGHT: begin
              cursor <= cursor + ADDR_W'(1);
              pc     <= pc_inc;
            end
            OP_LEFT: begin
              cursor <= cursor - ADDR_W'(1);
              pc     <= pc_inc;
            end
            OP_INC: begin
              out   <= i_din + DATA_W'(1);
              we    <= 1'b1;
              pc    <= pc_inc;
              state <= ST_WB;
            end
            OP_DEC: begin
              out   <= i_din - DATA_W'(1);
              we    <= 1'b1;
              pc    <= pc_inc;
              state <= ST_WB;
            end
            OP_PUT: begin
              tx_data  <= i_din;
              tx_valid <= 1'b1;
              pc       <= pc_inc;
              state    <= ST_WAIT_TX;
            end
            OP_GET: begin
              // Stall on this op until a keyboard byte is offered.
              if (kbd_valid) begin
                out     <= kbd_data;
                we      <= 1'b1;
                kbd_ack <= 1'b1;
                pc      <= pc_inc;
                state   <= ST_WB;
              end
            end
            OP_OPEN: begin
              if (!din_zero) begin
                if (stk_full) begin
                  error  <= 1'b1;
                  halted <= 1'b1;
                  state  <= ST_HALT;
                end else begin
                  pc <= pc_inc;
                end
              end else begin
                depth <= PC_W'(1);
                pc    <= pc_inc;
                state <= ST_SKIP;
              end
            end
            OP_CLOSE: begin
              if (stk_empty) begin
                error  <= 1'b1;
                halted <= 1'b1;
                state  <= ST_HALT;
              end else if (!din_zero) begin
                // Loop back to the op after the matching '['; entry stays.
                pc <= stk_top + PC_W'(1);
              end else begin
                pc <= pc_inc;
              end
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              pc <= pc_inc;
            end
          endcase
        end
        ST_WB: begin
          // RAM write lands at the end of this cycle; nothing reads i_din here.
          state <= ST_RUN;
        end
        ST_SKIP: begin
          if (i_prg == OP_HALT) begin
            error  <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (i_prg == OP_CLOSE && depth == PC_W'(1)) begin
            depth <= '0;
            pc    <= pc_inc;
            state <= ST_RUN;
          end else if (pc_inc == '0) begin
            // Ran off the end of program space without finding the ']'.
            error  <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (i_prg == OP_OPEN)  depth <= depth + PC_W'(1);
            if (i_prg == OP_CLOSE) depth <= depth - PC_W'(1);
            pc <= pc_inc;
          end
        end
        ST_WAIT_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule
